// File: rtl/crop_pkg.sv
// ---------------------------------------------------------------------------
// crop_pkg
// Shared definitions for the crop / binning pixel pipeline.
//   PIXEL_BIT_WIDTH_DEF : default pixel width
//   cnt_w(n)            : counter/address width able to index 0..n-1 (min 1)
//   pair_w(pw)          : width of a horizontal 2-pixel sum
//   sum_w(pw)           : width of a full 2x2 block sum
// ---------------------------------------------------------------------------
package crop_pkg;

    localparam int PIXEL_BIT_WIDTH_DEF = 12;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pair_w(input int pw);
        return pw + 1;
    endfunction

    function automatic int sum_w(input int pw);
        return pw + 2;
    endfunction

endpackage

// File: rtl/pixel_binner_2x2_if.sv
// ---------------------------------------------------------------------------
// pixel_binner_2x2_if
// Input and output pixel stream handshakes of the 2x2 binner.
//   pixel_in/in_valid/in_ready          : raster-order input stream
//   pixel_out/out_valid/out_ready/out_last : half-resolution output stream
// Modports: master = upstream/downstream environment, slave = the binner.
// ---------------------------------------------------------------------------
interface pixel_binner_2x2_if
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = PIXEL_BIT_WIDTH_DEF
);
    logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
    logic                       in_valid;
    logic                       in_ready;
    logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport master (
        output pixel_in, in_valid, out_ready,
        input  in_ready, pixel_out, out_valid, out_last
    );

    modport slave (
        input  pixel_in, in_valid, out_ready,
        output in_ready, pixel_out, out_valid, out_last
    );
endinterface

// File: rtl/pixel_binner_2x2_line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One-row store of horizontal pair sums. Registered write, combinational
// read. No reset: every entry is written on an even row before it is read.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
// ---------------------------------------------------------------------------
module line_buffer
    import crop_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int WIDTH = 13,
    localparam int AW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pixel_binner_2x2.sv
// ---------------------------------------------------------------------------
// pixel_binner_2x2
// Averages each non-overlapping 2x2 block of a raster-order stream and emits
// a half-resolution raster-order stream through a single-entry output reg.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of pixel_binner_2x2_if (input + output streams)
// ---------------------------------------------------------------------------
module pixel_binner_2x2
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = PIXEL_BIT_WIDTH_DEF,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_binner_2x2_if.slave    bus
);
    localparam int XW    = cnt_w(IN_COLS);
    localparam int YW    = cnt_w(IN_ROWS);
    localparam int LB_D  = IN_COLS / 2;
    localparam int AW    = cnt_w(LB_D);
    localparam int PAW   = pair_w(PIXEL_BIT_WIDTH);
    localparam int SW    = sum_w(PIXEL_BIT_WIDTH);

    // Average of four pixels: plain truncating divide by 4, cannot overflow.
    function automatic logic [PIXEL_BIT_WIDTH-1:0] div4(input logic [SW-1:0] s);
        return s[SW-1:2];
    endfunction

    logic [XW-1:0]              x_q, x_d;
    logic [YW-1:0]              y_q, y_d;
    logic [PIXEL_BIT_WIDTH-1:0] h_q, h_d;
    logic [PIXEL_BIT_WIDTH-1:0] pix_q, pix_d;
    logic                       vld_q, vld_d;
    logic                       last_q, last_d;

    logic           accept;
    logic           x_last, y_last;
    logic           lb_we;
    logic           result;
    logic [AW-1:0]  lb_addr;
    logic [PAW-1:0] pair;
    logic [PAW-1:0] lb_rdata;
    logic [SW-1:0]  sum;

    // in_ready depends only on registered out_valid and out_ready.
    assign bus.in_ready  = !vld_q || bus.out_ready;
    assign bus.pixel_out = pix_q;
    assign bus.out_valid = vld_q;
    assign bus.out_last  = last_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign x_last  = (x_q == XW'(IN_COLS - 1));
    assign y_last  = (y_q == YW'(IN_ROWS - 1));
    assign lb_addr = AW'(x_q >> 1);
    assign pair    = PAW'(h_q) + PAW'(bus.pixel_in);
    assign sum     = SW'(lb_rdata) + SW'(pair);

    // Odd column closes a horizontal pair: even rows park it, odd rows finish the block.
    assign lb_we   = accept && x_q[0] && !y_q[0];
    assign result  = accept && x_q[0] &&  y_q[0];

    line_buffer #(
        .DEPTH (LB_D),
        .WIDTH (PAW)
    ) u_line_buffer (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (pair),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        h_d    = h_q;
        pix_d  = pix_q;
        vld_d  = vld_q;
        last_d = last_q;

        if (accept) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            if (!x_q[0]) begin
                h_d = bus.pixel_in;
            end
        end

        // A new result overwrites the register even if it is being drained now.
        if (result) begin
            pix_d  = div4(sum);
            vld_d  = 1'b1;
            last_d = x_last && y_last;
        end else if (vld_q && bus.out_ready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            h_q    <= '0;
            pix_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            h_q    <= h_d;
            pix_q  <= pix_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end
endmodule

// File: doc/pixel_binner_2x2.md
# pixel_binner_2x2

Streaming 2x2 binning stage placed directly downstream of the crop filter. It consumes the cropped raster-order pixel stream, averages each non-overlapping 2x2 block, and emits a half-resolution stream in raster order. A one-row line buffer holds partial sums. A ready/valid handshake on both sides lets it drive the crop filter's `out_ready`.

## Interface

Parameters:
- `PIXEL_BIT_WIDTH`, default 12: pixel width, in and out.
- `IN_ROWS`, default 20: rows per input frame. Must be even and ≥ 2.
- `IN_COLS`, default 20: columns per input frame. Must be even and ≥ 2.

Ports:
- `clk`  input  1: single clock; all logic on rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `pixel_in`  input  `PIXEL_BIT_WIDTH`: input pixel, raster order.
- `in_valid`  input  1: `pixel_in` valid.
- `in_ready`  output  1: block can accept; connects to the crop filter's `out_ready`.
- `pixel_out`  output  `PIXEL_BIT_WIDTH`: binned pixel.
- `out_valid`  output  1: `pixel_out` valid.
- `out_ready`  input  1: downstream accepts.
- `out_last`  output  1: qualifies `pixel_out` as the final binned pixel of the frame.

## Operation

- Input accept: `in_valid && in_ready` on a rising edge.
- Output accept: `out_valid && out_ready` on a rising edge.
- Input position counters:
  - `x` (0..`IN_COLS`-1) and `y` (0..`IN_ROWS`-1) advance only on input accept.
  - `x` wraps to 0 and increments `y`.
  - `y` wraps to 0 after the last pixel of the frame.
- Horizontal pair register `h`, width `PIXEL_BIT_WIDTH`:
  - On even `x`, capture the pixel.
  - On odd `x`, form `pair = h + pixel_in`, width `PIXEL_BIT_WIDTH`+1.
- Even `y`, odd `x`: write `pair` into line buffer entry `x>>1`. Depth `IN_COLS/2`, width `PIXEL_BIT_WIDTH`+1.
- Odd `y`, odd `x`:
  - `sum = linebuf[x>>1] + pair`, width `PIXEL_BIT_WIDTH`+2.
  - `pixel_out <= sum >> 2`. Truncating; no rounding and no saturation needed.
  - Set `out_valid <= 1`.
  - Set `out_last <= 1` iff `x == IN_COLS-1` and `y == IN_ROWS-1`, else 0.
- Output register:
  - Single entry.
  - `in_ready = !out_valid || out_ready`, combinational.
  - On output accept with no new result, `out_valid <= 0`.
  - A result arriving in the same cycle as an output accept replaces the register; `out_valid` stays 1.
- Output count: exactly `(IN_ROWS/2)*(IN_COLS/2)` outputs per frame. `out_last` is high on the final one only.
- Stall: while `out_valid && !out_ready`, `pixel_out`, `out_valid` and `out_last` hold stable and `in_ready` is 0. No input is lost, since the upstream holds its pixel while `in_ready` is low.
- `in_valid` gaps: counters, `h` and line buffer hold; no state change.
- Reset (asserted at any time, including mid-frame):
  - Immediately `x=0`, `y=0`, `h=0`, `out_valid=0`, `out_last=0`, `pixel_out=0`.
  - Line buffer contents are not cleared; every entry is written on row 0 before it is read.
  - After reset release, the next accepted pixel is position (0,0).

## Timing

- Latency: `out_valid` rises on the clock edge that accepts the 4th pixel of a block (bottom-right, odd `x`/odd `y`). The result is visible the following cycle, i.e. 1-cycle registered latency.
- Throughput: 1 input pixel/cycle sustained when `out_ready` is held high. Outputs are at most 1 per 4 inputs.
- `in_ready` depends combinationally on `out_ready` and registered `out_valid` only. No combinational path from `in_valid` to `in_ready`.
- Line buffer: read and write within the same accept cycle, at different rows, so no read-during-write hazard. Implement as registers or as a RAM with asynchronous read.

## Structure

- Shared package `crop_pkg`:
  - `PIXEL_BIT_WIDTH` default.
  - Derived widths: `$clog2(IN_COLS)` and `$clog2(IN_ROWS)` for counters; `PIXEL_BIT_WIDTH+1` pair width; `PIXEL_BIT_WIDTH+2` sum width.
- Sub-module `line_buffer`:
  - Parameters `DEPTH`, `WIDTH`.
  - Ports: write enable, write address, write data, read address, read data (combinational).
- Top level holds the counters, pair register, adder and output register.

## Test plan

All scenarios use `IN_ROWS=4`, `IN_COLS=4`, `PIXEL_BIT_WIDTH=12` unless stated.

1. **Constant frame:** 16 pixels of value 100, `out_ready=1` → 4 outputs, all 100. `out_last` high on the 4th output only.
2. **Ramp frame:** `pixel = 4*y + x` → outputs 2, 4, 10, 12 in order. Each `out_valid` appears one cycle after accepting pixels 5, 7, 13, 15 (0-based).
3. **Full scale:** all pixels 4095 → all outputs 4095, no wrap. Pattern 4095, 4095, 4095, 4094 in one block → 4094 (truncation).
4. **Backpressure:** ramp frame with `out_ready=0` for 3 cycles while output 2 is pending → `in_ready=0` for those cycles, `pixel_out`=4 held stable. Sequence 2, 4, 10, 12 is intact.
5. **Idle gaps:** random `in_valid` low cycles inserted → outputs identical to scenario 2.
6. **Reset mid-frame:** assert `reset` low after 6 accepted pixels, release, send a fresh ramp frame → `out_valid` drops immediately. Outputs are 2, 4, 10, 12, with no stale result.
